// File: rtl/cla_pipelined_adder_16bits.sv
// Two-stage carry-lookahead adder: stage 1 registers operands with per-group PG/GG, stage 2 resolves carries.
// Latency 2 edges; the ready chain runs combinationally from out_ready, so it stalls without dropping results.
module cla_pipelined_adder_16bits #(
    parameter int GROUPS = 4,
    localparam int W = 4 * GROUPS
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in0,
    input  logic [W-1:0] in1,
    input  logic         carry_in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         carry_out,
    output logic         overflow
);

    logic              s1_valid_q, s1_valid_d;
    logic              s2_valid_q, s2_valid_d;
    logic [W-1:0]      a_q, b_q;
    logic              cin_q;
    logic [GROUPS-1:0] pg_q, pg_d;
    logic [GROUPS-1:0] gg_q, gg_d;
    logic [W-1:0]      sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              ovf_q, ovf_d;

    logic              s2_ready;
    logic              in_fire;
    logic              s12_fire;

    logic [W-1:0]      p1, g1;
    logic [W-1:0]      p2, g2;
    logic [GROUPS:0]   cg;
    logic [W-1:0]      c;

    assign s2_ready = ~s2_valid_q | out_ready;
    assign in_ready = ~s1_valid_q | s2_ready;
    assign in_fire  = in_valid & in_ready;
    assign s12_fire = s1_valid_q & s2_ready;

    assign s1_valid_d = in_fire  | (s1_valid_q & ~s2_ready);
    assign s2_valid_d = s12_fire | (s2_valid_q & ~out_ready);

    always_comb begin
        p1   = in0 ^ in1;
        g1   = in0 & in1;
        pg_d = '0;
        gg_d = '0;
        for (int k = 0; k < GROUPS; k++) begin
            pg_d[k] = &p1[4*k +: 4];
            gg_d[k] = g1[4*k+3]
                    | (g1[4*k+2] & p1[4*k+3])
                    | (g1[4*k+1] & p1[4*k+3] & p1[4*k+2])
                    | (g1[4*k]   & p1[4*k+3] & p1[4*k+2] & p1[4*k+1]);
        end
    end

    // Group carries come from the registered lookahead terms; each group then ripples from its own seed.
    always_comb begin
        p2    = a_q ^ b_q;
        g2    = a_q & b_q;
        cg    = '0;
        cg[0] = cin_q;
        for (int k = 0; k < GROUPS; k++) begin
            cg[k+1] = gg_q[k] | (pg_q[k] & cg[k]);
        end
        c = '0;
        for (int i = 0; i < W; i++) begin
            if (i % 4 == 0) begin
                c[i] = cg[i/4];
            end else begin
                c[i] = g2[i-1] | (p2[i-1] & c[i-1]);
            end
        end
        sum_d  = p2 ^ c;
        cout_d = cg[GROUPS];
        ovf_d  = c[W-1] ^ cg[GROUPS];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            cin_q      <= 1'b0;
            pg_q       <= '0;
            gg_q       <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            if (in_fire) begin
                a_q   <= in0;
                b_q   <= in1;
                cin_q <= carry_in;
                pg_q  <= pg_d;
                gg_q  <= gg_d;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            s2_valid_q <= s2_valid_d;
            if (s12_fire) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
                ovf_q  <= ovf_d;
            end
        end
    end

    assign out_valid = s2_valid_q;
    assign sum       = sum_q;
    assign carry_out = cout_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_cla_pipelined_adder_16bits.sv
// Bench for the pipelined 16-bit adder: directed corner cases plus a randomized handshake stream
// checked against a plain-arithmetic reference and an in-order expectation queue.
module tb_cla_pipelined_adder_16bits;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in0 = '0;
    logic [15:0] in1 = '0;
    logic        carry_in = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic        carry_out;
    logic        overflow;

    int n_vec = 0;
    int n_bad = 0;
    logic [17:0] expq[$];

    cla_pipelined_adder_16bits #(.GROUPS(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in0       (in0),
        .in1       (in1),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    // Reference result packed as {overflow, carry_out, sum}.
    function automatic logic [17:0] ref_add(input logic [15:0] a, input logic [15:0] b, input logic ci);
        logic [16:0] full;
        logic        ovf;
        full = {1'b0, a} + {1'b0, b} + {16'b0, ci};
        ovf  = (a[15] == b[15]) && (full[15] != a[15]);
        return {ovf, full};
    endfunction

    task automatic present(input logic [15:0] a, input logic [15:0] b, input logic ci);
        in0      = a;
        in1      = b;
        carry_in = ci;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        in0       = 16'($urandom);
        in1       = 16'($urandom);
        carry_in  = 1'b1;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_vec++; if (sum !== 16'h0000) begin n_bad++; $display("FAIL reset_sum: got %h expected 0000", sum); end
        n_vec++; if (carry_out !== 1'b0) begin n_bad++; $display("FAIL reset_carry_out: got %b expected 0", carry_out); end
        n_vec++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        @(posedge clk); #1;
    endtask

    task automatic test_ripple();
        out_ready = 1'b1;
        present(16'hFFFF, 16'h0001, 1'b0);
        n_vec++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL ripple_valid: got %b expected 1", out_valid); end
        n_vec++; if ({overflow, carry_out, sum} !== 18'h10000) begin n_bad++; $display("FAIL ripple_result: got %h expected 10000", {overflow, carry_out, sum}); end
        @(posedge clk); #1;
        n_vec++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL ripple_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_overflow();
        out_ready = 1'b1;
        present(16'h7FFF, 16'h0001, 1'b0);
        n_vec++; if ({out_valid, overflow, carry_out, sum} !== {1'b1, 18'h28000}) begin n_bad++; $display("FAIL ovf_pos: got %b/%h expected 1/28000", out_valid, {overflow, carry_out, sum}); end
        present(16'h8000, 16'h8000, 1'b0);
        n_vec++; if ({out_valid, overflow, carry_out, sum} !== {1'b1, 18'h30000}) begin n_bad++; $display("FAIL ovf_neg: got %b/%h expected 1/30000", out_valid, {overflow, carry_out, sum}); end
        present(16'h0123, 16'h0456, 1'b1);
        n_vec++; if ({overflow, carry_out, sum} !== ref_add(16'h0123, 16'h0456, 1'b1)) begin n_bad++; $display("FAIL cin_add: got %h expected %h", {overflow, carry_out, sum}, ref_add(16'h0123, 16'h0456, 1'b1)); end
        @(posedge clk); #1;
    endtask

    task automatic test_back_to_back();
        logic [15:0] exp_s[3];
        logic        exp_rdy[3];
        int          got;
        bit          acc;
        exp_s   = '{16'h0003, 16'h0007, 16'h000B};
        exp_rdy = '{1'b1, 1'b1, 1'b0};
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            in0      = 16'(2*i + 1);
            in1      = 16'(2*i + 2);
            carry_in = 1'b0;
            in_valid = 1'b1;
            @(negedge clk);
            n_vec++; if (in_ready !== exp_rdy[i]) begin n_bad++; $display("FAIL bp_in_ready[%0d]: got %b expected %b", i, in_ready, exp_rdy[i]); end
            @(posedge clk); #1;
        end
        @(negedge clk);
        n_vec++; if ({out_valid, sum, in_ready} !== {1'b1, 16'h0003, 1'b0}) begin n_bad++; $display("FAIL bp_hold: got v=%b s=%h r=%b expected v=1 s=0003 r=0", out_valid, sum, in_ready); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        got = 0;
        acc = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            if (in_valid && in_ready) acc = 1'b1;
            if (out_valid && out_ready) begin
                n_vec++;
                if (got >= 3) begin
                    n_bad++; $display("FAIL bp_extra: got result %h expected none", sum);
                end else if (sum !== exp_s[got]) begin
                    n_bad++; $display("FAIL bp_order[%0d]: got %h expected %h", got, sum, exp_s[got]);
                end
                got++;
            end
            @(posedge clk); #1;
            if (acc) in_valid = 1'b0;
        end
        n_vec++; if (got != 3) begin n_bad++; $display("FAIL bp_count: got %0d results expected 3", got); end
    endtask

    task automatic test_reset_midflight();
        out_ready = 1'b1;
        in0       = 16'h1234;
        in1       = 16'h1111;
        carry_in  = 1'b0;
        in_valid  = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        n_vec++; if ({out_valid, sum} !== 17'h0) begin n_bad++; $display("FAIL mid_async: got v=%b s=%h expected v=0 s=0000", out_valid, sum); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            n_vec++; if (out_valid !== 1'b0 || sum === 16'h2345) begin n_bad++; $display("FAIL mid_discard[%0d]: got v=%b s=%h expected v=0", i, out_valid, sum); end
        end
        present(16'h0001, 16'h0002, 1'b0);
        n_vec++; if ({out_valid, sum} !== {1'b1, 16'h0003}) begin n_bad++; $display("FAIL mid_first: got v=%b s=%h expected v=1 s=0003", out_valid, sum); end
        @(posedge clk); #1;
    endtask

    task automatic test_stream();
        bit          acc;
        bit          stalled;
        logic [17:0] held;
        logic [17:0] obs;
        logic [17:0] exp_v;
        acc     = 1'b1;
        stalled = 1'b0;
        held    = '0;
        expq.delete();
        for (int cyc = 0; cyc < 10010; cyc++) begin
            if (cyc < 10000) begin
                if (acc || !in_valid) begin
                    in_valid = ($urandom % 10) < 7;
                    in0      = 16'($urandom);
                    in1      = 16'($urandom);
                    carry_in = 1'($urandom);
                end
                out_ready = ($urandom % 10) < 7;
            end else begin
                in_valid  = 1'b0;
                out_ready = 1'b1;
            end
            @(negedge clk);
            obs = {overflow, carry_out, sum};
            acc = in_valid && in_ready;
            if (acc) expq.push_back(ref_add(in0, in1, carry_in));
            if (stalled) begin
                n_vec++;
                if (!out_valid || obs !== held) begin n_bad++; $display("FAIL stream_hold@%0d: got v=%b %h expected v=1 %h", cyc, out_valid, obs, held); end
            end
            if (out_valid && out_ready) begin
                n_vec++;
                if (expq.size() == 0) begin
                    n_bad++; $display("FAIL stream_spurious@%0d: got %h expected no result", cyc, obs);
                end else begin
                    exp_v = expq.pop_front();
                    if (obs !== exp_v) begin n_bad++; $display("FAIL stream_result@%0d: got %h expected %h", cyc, obs, exp_v); end
                end
            end
            stalled = out_valid && !out_ready;
            held    = obs;
            @(posedge clk); #1;
        end
        n_vec++; if (expq.size() != 0) begin n_bad++; $display("FAIL stream_lost: got %0d pending expected 0", expq.size()); end
    endtask

    initial begin
        test_reset();
        test_ripple();
        test_overflow();
        test_back_to_back();
        test_reset_midflight();
        test_stream();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
